fxp_horner_eval: RTL and testbench
==================================

Name: fxp_horner_eval

Overview:
- Sequencer directly upstream of the fixed-point ALU. Evaluates the polynomial p(x) = c[d]·x^d + … + c[0] by Horner's rule.
- Drives the ALU operand and opcode inputs, and registers the ALU result back each cycle.
- Holds a small coefficient bank written by the host. Returns a Q-format result with a done pulse.
- The ALU is combinational and instantiated outside this block; one ALU operation completes per clock.

Parameters:
- N, 32, word width (two's complement fixed point).
- Q, 12, fractional bits; 1.0 = 2^Q.
- DEG_W, 3, degree field width; coefficient bank depth = 2^DEG_W.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous active-low reset.
- coef_wr_en  input  1  coefficient write strobe.
- coef_wr_addr  input  DEG_W  coefficient index.
- coef_wr_data  input  N  coefficient value.
- start  input  1  begin evaluation; sampled only when busy=0.
- x_in  input  N  evaluation point; latched on accepted start.
- degree  input  DEG_W  polynomial degree d; latched on accepted start.
- busy  output  1  evaluation in progress.
- done  output  1  one-cycle pulse; result valid from this cycle.
- result  output  N  registered p(x); held until next done.
- alu_a  output  N  ALU operand a.
- alu_b  output  N  ALU operand b.
- alu_op  output  2  ALU opcode: 00 add, 01 sub, 10 mult.
- alu_out  input  N  ALU result (combinational from alu_a/alu_b/alu_op).

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=IDLE; busy=0, done=0, result=0.
  - alu_a=0, alu_b=0, alu_op=00.
  - Coefficient bank is cleared to 0.
  - Reset mid-evaluation aborts it with no done.
- States and transitions:
  - IDLE: start=1 at edge E latches x and d, sets acc<=c[d], idx<=d, busy<=1. Next state is MUL if d>0, else FIN.
  - MUL: alu_a=acc, alu_b=x_reg, alu_op=10; acc<=alu_out; next ADD.
  - ADD: alu_a=acc, alu_b=c[idx-1], alu_op=00; acc<=alu_out; idx<=idx-1. Next state FIN if idx-1==0, else MUL.
  - FIN: result<=acc, done<=1, busy<=0; next IDLE.
- ALU drive:
  - alu_a, alu_b and alu_op are driven combinationally from state/acc/x_reg/bank.
  - In IDLE and FIN they are 0/0/00.
- Latency and output timing:
  - Start accepted at edge E; done is high for exactly one cycle after edge E+2d+1.
  - d=0 gives 1-cycle latency; d=7 gives 15 cycles.
  - busy is high from after edge E until after edge E+2d+1.
- start handling:
  - start while busy=1 is ignored; no queuing.
  - start held high continuously re-triggers on the cycle after done, because busy=0 in that cycle.
- Coefficient writes:
  - Commit at the edge when coef_wr_en=1, busy=0 and start=0.
  - Writes while busy, or in the same cycle as an accepted start, are dropped. The bank is therefore stable for a whole evaluation.
- Arithmetic:
  - Width, wrap and quantization are exactly as the ALU defines them.
  - No saturation in this block; the ALU output 0x80000000 already arrives as 0.
- Boundary conditions:
  - degree=0 returns c[0] unchanged, with no ALU operations.
  - idx never underflows.
- done and result:
  - done is never asserted twice per start.
  - result is unchanged between done pulses.

Optional Feature:
- Macro: FXP_HORNER_OVF_EN.
- With the macro defined:
  - Extra output port ovf (1 bit), reset to 0.
  - ovf is cleared on an accepted start.
  - ovf is sticky-set in ADD when alu_a[N-1]==alu_b[N-1] and alu_out[N-1]!=alu_a[N-1].
  - ovf is valid alongside done.
- Without the macro: no ovf port and no detection logic; all other behaviour is identical.

Test Plan:
- Positive polynomial: c2=0x00002000, c1=0x00003000, c0=0x00001000, x=0x00002000, d=2, start at E → done after edge E+5, result=0x0000F000 (15.0), busy high for 5 cycles.
- Negative operands: c2=0x00001000, c1=0, c0=0xFFFFF000, x=0xFFFFE800 (−1.5), d=2 → result=0x00001400 (1.25).
- Degree 0: c0=0x00005000, d=0 → done after edge E+1, result=0x00005000, alu_op stays 00 and no MUL cycle occurs.
- Protocol: start pulsed again, plus a coef write to c0=0x00009000, both during busy in the positive-polynomial case → exactly one done, result=0x0000F000. A follow-up start then gives 0x0000F000 again, since the write was dropped.
- Reset mid-op: assert rst_n=0 during a MUL of a d=3 run → busy=0, done=0, result=0, and all coefficients read back 0 on the next d=0 run.
- With FXP_HORNER_OVF_EN: c1=0x7FFFF000, c0=0x00002000, x=0x00001000, d=1 → result=0x80001000, ovf=1 with done. A next run of the positive-polynomial case clears ovf=0.

Source files
------------

// File: rtl/fxp_horner_eval_if.sv
// rtl/fxp_horner_eval_if.sv - operand/opcode/result bus between the Horner sequencer and the ALU
interface fxp_horner_eval_if #(
  parameter int N = 32
);
  logic [N-1:0] alu_a;
  logic [N-1:0] alu_b;
  logic [1:0]   alu_op;
  logic [N-1:0] alu_out;

  modport master (output alu_a, output alu_b, output alu_op, input alu_out);
  modport slave  (input alu_a, input alu_b, input alu_op, output alu_out);
endinterface

// File: rtl/fxp_horner_eval.sv
// rtl/fxp_horner_eval.sv - Horner polynomial sequencer driving an external fixed-point ALU
// Optional sticky overflow flag on the accumulate step: FXP_HORNER_OVF_EN.
module fxp_horner_eval #(
  parameter int N     = 32,
  parameter int Q     = 12,
  parameter int DEG_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             coef_wr_en,
  input  logic [DEG_W-1:0] coef_wr_addr,
  input  logic [N-1:0]     coef_wr_data,
  input  logic             start,
  input  logic [N-1:0]     x_in,
  input  logic [DEG_W-1:0] degree,
  output logic             busy,
  output logic             done,
  output logic [N-1:0]     result,
`ifdef FXP_HORNER_OVF_EN
  output logic             ovf,
`endif
  fxp_horner_eval_if.master alu
);

  localparam int DEPTH = 2 ** DEG_W;

  if (Q >= N) begin : g_q_range
    $error("fxp_horner_eval: Q must be smaller than N");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    ADD  = 2'd2,
    FIN  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [N-1:0]     acc_q, acc_d;
  logic [N-1:0]     x_q, x_d;
  logic [DEG_W-1:0] idx_q, idx_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [N-1:0]     result_q, result_d;
  logic [N-1:0]     bank_q [DEPTH];
  logic [N-1:0]     bank_d [DEPTH];
  logic [DEG_W-1:0] idx_m1;
`ifdef FXP_HORNER_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    x_d        = x_q;
    idx_d      = idx_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    result_d   = result_q;
    bank_d     = bank_q;
    idx_m1     = idx_q - 1'b1;
    alu.alu_a  = '0;
    alu.alu_b  = '0;
    alu.alu_op = 2'b00;
`ifdef FXP_HORNER_OVF_EN
    ovf_d      = ovf_q;
`endif

    // Bank only changes while idle and not starting, so it is frozen for a whole evaluation.
    if (coef_wr_en && !busy_q && !start) begin
      bank_d[coef_wr_addr] = coef_wr_data;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          x_d     = x_in;
          acc_d   = bank_q[degree];
          idx_d   = degree;
          busy_d  = 1'b1;
          state_d = (degree != '0) ? MUL : FIN;
`ifdef FXP_HORNER_OVF_EN
          ovf_d   = 1'b0;
`endif
        end
      end
      MUL: begin
        alu.alu_a  = acc_q;
        alu.alu_b  = x_q;
        alu.alu_op = 2'b10;
        acc_d      = alu.alu_out;
        state_d    = ADD;
      end
      ADD: begin
        // idx_q >= 1 here: ADD is only reached through MUL, which requires a non-zero degree.
        alu.alu_a  = acc_q;
        alu.alu_b  = bank_q[idx_m1];
        alu.alu_op = 2'b00;
        acc_d      = alu.alu_out;
        idx_d      = idx_m1;
        state_d    = (idx_m1 == '0) ? FIN : MUL;
`ifdef FXP_HORNER_OVF_EN
        if ((acc_q[N-1] == bank_q[idx_m1][N-1]) && (alu.alu_out[N-1] != acc_q[N-1])) begin
          ovf_d = 1'b1;
        end
`endif
      end
      FIN: begin
        result_d = acc_q;
        done_d   = 1'b1;
        busy_d   = 1'b0;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      x_q      <= '0;
      idx_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        bank_q[i] <= '0;
      end
`ifdef FXP_HORNER_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      x_q      <= x_d;
      idx_q    <= idx_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
      for (int i = 0; i < DEPTH; i++) begin
        bank_q[i] <= bank_d[i];
      end
`ifdef FXP_HORNER_OVF_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
`ifdef FXP_HORNER_OVF_EN
  assign ovf    = ovf_q;
`endif

endmodule

// File: tb/tb_fxp_horner_eval.sv
// tb/tb_fxp_horner_eval.sv - directed scoreboard bench for fxp_horner_eval with a behavioural Q12 ALU
module tb_fxp_horner_eval;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        coef_wr_en;
  logic [2:0]  coef_wr_addr;
  logic [31:0] coef_wr_data;
  logic        start;
  logic [31:0] x_in;
  logic [2:0]  degree;
  logic        busy;
  logic        done;
  logic [31:0] result;
`ifdef FXP_HORNER_OVF_EN
  logic        ovf;
`endif

  typedef struct {
    logic [31:0] res;
    logic        ovf;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] coef_m [8];
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  fxp_horner_eval_if #(.N(32)) alu_if ();

  fxp_horner_eval #(.N(32), .Q(12), .DEG_W(3)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .coef_wr_en   (coef_wr_en),
    .coef_wr_addr (coef_wr_addr),
    .coef_wr_data (coef_wr_data),
    .start        (start),
    .x_in         (x_in),
    .degree       (degree),
    .busy         (busy),
    .done         (done),
    .result       (result),
`ifdef FXP_HORNER_OVF_EN
    .ovf          (ovf),
`endif
    .alu          (alu_if)
  );

  // Q12 ALU: wrapping add/sub, truncating multiply, 0x80000000 folded to 0.
  function automatic logic [31:0] alu_model(logic [31:0] a, logic [31:0] b, logic [1:0] op);
    logic signed [63:0] p;
    logic [31:0]        r;
    case (op)
      2'b00: r = a + b;
      2'b01: r = a - b;
      2'b10: begin
        p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        p = p >>> 12;
        r = p[31:0];
      end
      default: r = '0;
    endcase
    if (r == 32'h8000_0000) r = '0;
    return r;
  endfunction

  assign alu_if.alu_out = alu_model(alu_if.alu_a, alu_if.alu_b, alu_if.alu_op);

  function automatic logic [31:0] horner_ref(logic [31:0] x, int d);
    logic [31:0] acc;
    acc = coef_m[d];
    for (int i = d; i > 0; i--) begin
      acc = alu_model(alu_model(acc, x, 2'b10), coef_m[i-1], 2'b00);
    end
    return acc;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && done === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("spurious_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("result_at_done", result, e.res);
`ifdef FXP_HORNER_OVF_EN
        chk("ovf_at_done", {31'd0, ovf}, {31'd0, e.ovf});
`endif
      end
    end
  end

  task automatic wr_coef(input logic [2:0] a, input logic [31:0] v);
    @(negedge clk);
    coef_wr_en = 1'b1; coef_wr_addr = a; coef_wr_data = v;
    coef_m[a] = v;
    @(negedge clk);
    coef_wr_en = 1'b0;
  endtask

  task automatic run_eval(input logic [31:0] x, input logic [2:0] d, input logic [31:0] expv,
                          input logic exp_ovf, input bit disturb);
    int   k;
    int   busy_cyc;
    int   mul_cyc;
    exp_t e;
    @(negedge clk);
    x_in = x; degree = d; start = 1'b1;
    e.res = expv; e.ovf = exp_ovf;
    exp_q.push_back(e);
    @(negedge clk);
    start = 1'b0;
    k = 0; busy_cyc = 0; mul_cyc = 0;
    while (done !== 1'b1 && k < 40) begin
      if (busy === 1'b1) busy_cyc++;
      if (alu_if.alu_op === 2'b10) mul_cyc++;
      if (disturb && k == 1) begin
        start = 1'b1; coef_wr_en = 1'b1; coef_wr_addr = 3'd0; coef_wr_data = 32'h0000_9000;
      end
      if (disturb && k == 2) begin
        start = 1'b0; coef_wr_en = 1'b0;
      end
      @(negedge clk);
      k++;
    end
    chk("done_latency", k, 2 * int'(d) + 1);
    chk("busy_cycles", busy_cyc, 2 * int'(d) + 1);
    chk("mul_cycles", mul_cyc, int'(d));
    chk("busy_low_at_done", {31'd0, busy}, 32'd0);
    @(negedge clk);
    chk("done_one_cycle", {31'd0, done}, 32'd0);
    chk("result_held", result, expv);
  endtask

  initial begin
    rst_n = 1'b0; coef_wr_en = 1'b0; coef_wr_addr = '0; coef_wr_data = '0;
    start = 1'b0; x_in = '0; degree = '0;
    for (int i = 0; i < 8; i++) coef_m[i] = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_alu_a", alu_if.alu_a, 32'd0);
    chk("rst_alu_b", alu_if.alu_b, 32'd0);
    chk("rst_alu_op", {30'd0, alu_if.alu_op}, 32'd0);
    rst_n = 1'b1;

    wr_coef(3'd2, 32'h0000_2000); wr_coef(3'd1, 32'h0000_3000); wr_coef(3'd0, 32'h0000_1000);
    run_eval(32'h0000_2000, 3'd2, 32'h0000_F000, 1'b0, 1'b0);

    wr_coef(3'd2, 32'h0000_1000); wr_coef(3'd1, 32'h0000_0000); wr_coef(3'd0, 32'hFFFF_F000);
    run_eval(32'hFFFF_E800, 3'd2, 32'h0000_1400, 1'b0, 1'b0);

    wr_coef(3'd2, 32'h0000_2000); wr_coef(3'd1, 32'h0000_3000); wr_coef(3'd0, 32'h0000_1000);
    run_eval(32'h0000_2000, 3'd2, 32'h0000_F000, 1'b0, 1'b1);
    run_eval(32'h0000_2000, 3'd2, 32'h0000_F000, 1'b0, 1'b0);

    wr_coef(3'd0, 32'h0000_5000);
    run_eval(32'h0000_2000, 3'd0, 32'h0000_5000, 1'b0, 1'b0);

    wr_coef(3'd1, 32'hFFFF_C000); wr_coef(3'd0, 32'h0000_0800);
    run_eval(32'h0000_3000, 3'd1, 32'hFFFF_4800, 1'b0, 1'b0);

    for (int i = 0; i < 8; i++) wr_coef(3'(i), 32'(i * 4096 - 12288));
    run_eval(32'h0000_0800, 3'd7, horner_ref(32'h0000_0800, 7), 1'b0, 1'b0);

`ifdef FXP_HORNER_OVF_EN
    wr_coef(3'd1, 32'h7FFF_F000); wr_coef(3'd0, 32'h0000_2000);
    run_eval(32'h0000_1000, 3'd1, 32'h8000_1000, 1'b1, 1'b0);
    wr_coef(3'd2, 32'h0000_2000); wr_coef(3'd1, 32'h0000_3000); wr_coef(3'd0, 32'h0000_1000);
    run_eval(32'h0000_2000, 3'd2, 32'h0000_F000, 1'b0, 1'b0);
`endif

    for (int i = 0; i < 4; i++) wr_coef(3'(i), 32'h0000_1000);
    @(negedge clk);
    x_in = 32'h0000_1000; degree = 3'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("abort_in_mul", {30'd0, alu_if.alu_op}, 32'd2);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_result", result, 32'd0);
    chk("abort_alu_a", alu_if.alu_a, 32'd0);
    for (int i = 0; i < 8; i++) coef_m[i] = '0;
    repeat (4) begin
      @(negedge clk);
      chk("no_done_after_abort", {31'd0, done}, 32'd0);
    end
    run_eval(32'h0000_1000, 3'd0, 32'd0, 1'b0, 1'b0);
    run_eval(32'h0000_1000, 3'd3, 32'd0, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    chk("all_results_seen", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
